// File: rtl/syncfifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky ovf/udf.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module syncfifo_param #(
    parameter int DT_WIDTH   = 8,
    parameter int F_DEPTH    = 16,
    parameter int FADD_WIDTH = $clog2(F_DEPTH),
    parameter int AF_THRESH  = F_DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrt_en,
    input  logic [DT_WIDTH-1:0]   wrt_dt,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DT_WIDTH-1:0]   rd_dt,
    output logic                  rd_vld,
    output logic                  f_full,
    output logic                  f_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [FADD_WIDTH:0]   count,
    output logic                  ovf,
    output logic                  udf
);

    localparam logic [FADD_WIDTH:0] AF_LVL = (FADD_WIDTH+1)'(AF_THRESH);
    localparam logic [FADD_WIDTH:0] AE_LVL = (FADD_WIDTH+1)'(AE_THRESH);

    logic [DT_WIDTH-1:0] mem [F_DEPTH];
    logic [FADD_WIDTH:0] wp;
    logic [FADD_WIDTH:0] rp;
    logic                wr_acc;
    logic                rd_acc;

    // The MSB is the wrap bit: equal low bits with differing MSBs means a full lap ahead.
    assign f_full  = (wp[FADD_WIDTH] != rp[FADD_WIDTH]) &&
                     (wp[FADD_WIDTH-1:0] == rp[FADD_WIDTH-1:0]);
    assign f_empty = (wp == rp);

    assign wr_acc = wrt_en & ~f_full;
    assign rd_acc = rd_en & ~f_empty;

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // NOTE: storage has no reset; pointers define validity, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wp[FADD_WIDTH-1:0]] <= wrt_dt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_acc)
                wp <= wp + 1'b1;
            if (rd_acc)
                rp <= rp + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (ovf & ~clr_err) | (wrt_en & f_full);
            udf <= (udf & ~clr_err) | (rd_en & f_empty);
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_dt  = mem[rp[FADD_WIDTH-1:0]];
    assign rd_vld = ~f_empty;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dt  <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_acc)
                rd_dt <= mem[rp[FADD_WIDTH-1:0]];
        end
    end
`endif

endmodule
